// File: rtl/hi_lo_mult_pkg.sv
// Shared definitions for the HI/LO multiply unit: move-request encodings
// and the operand magnitude helper used when a signed multiply is latched.
`ifndef MOVE_NONE
`define MOVE_NONE 2'b00
`endif
`ifndef MOVE_HI
`define MOVE_HI 2'b01
`endif
`ifndef MOVE_LO
`define MOVE_LO 2'b10
`endif

package hi_lo_mult_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 64;

  localparam logic [1:0] MV_NONE = `MOVE_NONE;
  localparam logic [1:0] MV_HI   = `MOVE_HI;
  localparam logic [1:0] MV_LO   = `MOVE_LO;

  // 0x80000000 maps to itself and is then read as unsigned 2^31.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v,
                                              input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hi_lo_mult_step.sv
// One CALC iteration of the shift-add multiplier: retires BITS_PER_CYCLE
// multiplier bits into the accumulator and advances both operands.
module hi_lo_mult_step
  import hi_lo_mult_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [ACC_W-1:0]  mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [ACC_W-1:0]  mcand_o,
  output logic [DATA_W-1:0] mplier_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_i[i]) acc_o = acc_o + (mcand_i << i);
    end
    mcand_o  = mcand_i << BITS_PER_CYCLE;
    mplier_o = mplier_i >> BITS_PER_CYCLE;
  end

endmodule

// File: rtl/hi_lo_mult_unit.sv
// Execute-stage multiply unit owning HI/LO: iterative MULT/MULTU, MFHI/MFLO
// reads, and a stall to the pipeline while a multiply is in flight.
module hi_lo_mult_unit
  import hi_lo_mult_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mult_start,
  input  logic              mult_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [1:0]        move_hi_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] move_data,
  output logic              busy,
  output logic              stall
);

  localparam int K     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e              state_q;
  logic [ACC_W-1:0]    acc_q, mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic [ACC_W-1:0]    acc_d, mcand_d;
  logic [DATA_W-1:0]   mplier_d;
  logic                rd_req;

  hi_lo_mult_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (mult_start) begin
          state_q  <= S_CALC;
          mcand_q  <= {32'd0, mag32(op_a, mult_signed)};
          mplier_q <= mag32(op_b, mult_signed);
          neg_q    <= mult_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
          acc_q    <= '0;
          cnt_q    <= CNT_LAST;
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          // Sign is applied once to the full 64-bit magnitude product.
          {hi_q, lo_q} <= neg_q ? (~acc_q + 64'd1) : acc_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_req = (move_hi_lo == MV_HI) || (move_hi_lo == MV_LO);
  assign busy   = (state_q != S_IDLE);
  assign stall  = busy & (rd_req | mult_start);
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_comb begin
    case (move_hi_lo)
      MV_HI:   move_data = hi_q;
      MV_LO:   move_data = lo_q;
      default: move_data = '0;
    endcase
  end

endmodule

// File: doc/hi_lo_mult_unit.md
# hi_lo_mult_unit

Multicycle multiply unit that owns the HI/LO architectural registers and acts on the control signals produced by decode. It executes MULT/MULTU with an iterative shift-add datapath and serves MFHI/MFLO reads through `move_hi_lo`. It raises `stall` to the pipeline whenever a request cannot be serviced in the current cycle. It sits in the execute stage beside the ALU.

## Interface
- `BITS_PER_CYCLE`, default 1. Multiplier bits retired per CALC cycle. Legal values are 1, 2, 4.
- `clk` input 1. Single clock; all state updates on the rising edge.
- `rst_n` input 1. Synchronous, active-low reset.
- `mult_start` input 1. Decode issued MULT or MULTU this cycle.
- `mult_signed` input 1. 1 = MULT (two's complement), 0 = MULTU. Sampled with `mult_start`.
- `op_a` input 32. rs operand, sampled with `mult_start`.
- `op_b` input 32. rt operand, sampled with `mult_start`.
- `move_hi_lo` input 2. Read request: 00 none, 01 MFHI, 10 MFLO, 11 none.
- `hi` output 32. HI register.
- `lo` output 32. LO register.
- `move_data` output 32. Value selected by `move_hi_lo`; 0 when there is no request.
- `busy` output 1. A multiply is in flight.
- `stall` output 1. The pipeline must hold the current execute instruction.

## Operation
- FSM states and transitions:
  - IDLE → CALC on `mult_start`.
  - CALC lasts K = 32/BITS_PER_CYCLE cycles, then → FIX.
  - FIX → IDLE unconditionally.
- Entry to CALC:
  - Latch |op_a| and |op_b|. Magnitudes are taken only when `mult_signed`=1; otherwise operands are latched unmodified.
  - Latch `neg` = mult_signed & (op_a[31] ^ op_b[31]).
  - Clear the 64-bit accumulator.
- Each CALC cycle:
  - Add (multiplicand × low BITS_PER_CYCLE bits of multiplier) into the accumulator.
  - Shift the multiplier right by BITS_PER_CYCLE and the multiplicand left by BITS_PER_CYCLE.
  - The counter counts K-1 down to 0.
- FIX: {hi,lo} ← neg ? two's-complement negation of the 64-bit accumulator : accumulator. This is the only cycle in which HI/LO change.
- `busy` = (state != IDLE), decoded from state.
- `stall` = busy & ((move_hi_lo ∈ {01,10}) | mult_start).
- `move_data` is combinational from the current hi/lo. MFHI/MFLO in IDLE are serviced the same cycle with no stall.
- `mult_start` while busy is not accepted. It is held by `stall` and accepted on the first cycle in IDLE.
- `mult_start` and `move_hi_lo` together in IDLE: the read returns the old HI/LO (MIPS hazard semantics). The multiply is accepted.
- Width rules:
  - The 64-bit accumulator never overflows.
  - Magnitude of 0x80000000 is 0x80000000, treated as an unsigned 32-bit value.
- Reset:
  - State → IDLE; hi = lo = 0; busy = stall = 0.
  - Accumulator and counter are cleared.
  - Reset mid-CALC or mid-FIX discards the operation, and HI/LO read 0.

## Timing
- `mult_start` is sampled at edge E0.
- CALC occupies edges E1..EK; FIX result is registered at edge E(K+1).
- `busy` is high for exactly K+1 cycles (K=32 gives 33 cycles).
- An MFHI issued in the cycle after E(K+1) sees the new value with no stall.
- Back-to-back MULT: the second `mult_start` is held until E(K+1). It is accepted at that edge's following cycle, so there are no lost or double-accepted starts.
- No combinational path from `op_a`/`op_b` to any output.

## Structure
- Move encodings go in the shared includes header as `define constants beside the existing opcode/funct definitions: `MOVE_NONE` 2'b00, `MOVE_HI` 2'b01, `MOVE_LO` 2'b10.
- FSM state encodings are local to the module.
- One sub-module, `hi_lo_mult_step`:
  - Purely combinational, parameterised by BITS_PER_CYCLE.
  - Returns the next accumulator, multiplicand and multiplier.
  - The FSM, counter, sign fix and HI/LO registers stay in the top module.

## Test plan
- Reset, then MFHI and MFLO: `move_data` = 0, `stall` = 0, hi = lo = 0.
- MULTU 7 × 6, BITS_PER_CYCLE=1: `busy` high for 33 cycles, then hi = 0x00000000, lo = 0x0000002A. MFLO returns 0x2A.
- MULT 0xFFFFFFFD × 5 (−3×5): hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF gives hi = 0xFFFFFFFE, lo = 0x00000001. MULT 0x80000000 × 0x80000000 gives hi = 0x40000000, lo = 0.
- MFHI asserted on the cycle after start: `stall` = 1 through the last busy cycle, then the new HI value is returned with `stall` = 0. A second `mult_start` during busy is held and executes exactly once.
- `rst_n` = 0 at cycle 10 of a multiply: next cycle busy = 0, hi = lo = 0. A fresh MULTU 3 × 3 yields lo = 9. Repeat with BITS_PER_CYCLE=4: `busy` is high for 9 cycles.
